dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the 32-bit non-pipelined MIPS core; the memory end of the core's data bus.
- Services loads (lb/lbu/lh/lhu/lw) and stores (sb/sh/sw) with a fixed number of wait states and a one-cycle ready pulse.
- Gives testbenches a realistic slow data memory in place of the zero-latency array.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 4.
WAIT_STATES, 1, cycles spent in WAIT before the response; 0 to 15.

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-low; 0 = reset
req  input  1  request strobe from core; sampled only in IDLE
memwrite  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
unsigned_ld  input  1  1 = zero-extend byte/half load, 0 = sign-extend
dataadr  input  32  byte address
writedata  input  32  store data; byte/half taken from low bits
readdata  output  32  load result, valid when ready=1
ready  output  1  single-cycle completion pulse
misalign_err  output  1  qualifies ready: access was misaligned and aborted

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, readdata=0, ready=0, misalign_err=0. Memory array is not reset; contents are undefined until written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 at a rising edge latches memwrite, size, unsigned_ld, dataadr and writedata.
  - Next state is WAIT with counter=WAIT_STATES-1, or RESP directly if WAIT_STATES=0.
  - req=0 stays in IDLE.
- WAIT:
  - Counter decrements each cycle; when it is 0, the next state is RESP.
  - Bus inputs are ignored; only the latched copy is used.
- Access commit: on the edge entering RESP, the store writes the array and the load result registers into readdata, both using the latched request.
- RESP:
  - ready=1 for exactly one cycle, then IDLE.
  - req high during RESP is ignored; a new request is accepted the following cycle in IDLE.
- Latency: ready is asserted WAIT_STATES+1 cycles after the accepting edge, so back-to-back requests occupy WAIT_STATES+2 cycles each.
- Addressing:
  - Word index = dataadr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses alias.
  - Little-endian byte lanes: byte k = bits [8k+7:8k], k = dataadr[1:0]. Halfword at dataadr[1]=0 is [15:0]; at dataadr[1]=1 it is [31:16].
- Stores:
  - sb writes only the selected byte lane; sh writes two lanes; sw writes all four.
  - Other lanes are preserved.
- Loads:
  - Selected byte/half is right-justified in readdata.
  - Upper bits are sign-extended when unsigned_ld=0 and zero-filled when unsigned_ld=1.
  - Word loads ignore unsigned_ld.
- Misalignment:
  - A halfword with dataadr[0]=1, or a word with dataadr[1:0]≠0, is misaligned.
  - The access still takes full latency, but no array write happens.
  - readdata=0; misalign_err=1 together with ready; both return to 0 the next cycle.
- Outside RESP, readdata holds its last value and misalign_err=0.
- Reset mid-operation: asserting reset in WAIT aborts the request with no write and no ready. Reset during the commit edge takes priority, so no write occurs.

Test Plan:
1. WAIT_STATES=1: sw 0x80007F02 to 84, then lw 84 → ready 2 cycles after each acceptance; readdata=0x80007F02, misalign_err=0.
2. After test 1: lbu 84 → 0x00000002; lb 85 → 0x0000007F; lb 87 → 0xFFFFFF80; lhu 86 → 0x00008000; lh 86 → 0xFFFF8000.
3. sw 0xFFFFFFFF to 80, then sb 0x12 to 81, then lw 80 → 0xFFFF12FF. sh 0xABCD to 82, then lw 80 → 0xABCD12FF.
4. Misaligned: sw to 82 and lh at 85, each → ready with misalign_err=1 and readdata=0. lw 80 afterwards is unchanged (0xABCD12FF).
5. WAIT_STATES=0: hold req high with alternating sw/lw to 0x0 → ready on the cycle after each acceptance, one request per 2 cycles. With DEPTH_WORDS=64, an address of 256 aliases to 0.
6. Reset in WAIT during sw 0x5555AAAA to 84 → outputs go to 0 immediately, no ready pulse. After release, lw 84 returns the previous value 0x80007F02.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: slow data memory for the 32-bit non-pipelined MIPS core.
// Services lb/lbu/lh/lhu/lw and sb/sh/sw with WAIT_STATES wait cycles, then
// raises ready for one cycle. Misaligned half/word accesses take the full
// latency, write nothing, return readdata=0 and flag misalign_err with ready.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req          request strobe, sampled only while idle
//   memwrite     1 = store, 0 = load
//   size         00 byte, 01 halfword, 10/11 word
//   unsigned_ld  1 = zero-extend byte/half loads, 0 = sign-extend
//   dataadr      byte address (upper bits alias)
//   writedata    store data, byte/half taken from the low bits
//   readdata     load result, valid with ready
//   ready        one-cycle completion pulse
//   misalign_err qualifies ready: access was misaligned and aborted
//
// state  | meaning
// S_IDLE | waiting for req; accepts and latches the request
// S_WAIT | counting down wait states on the latched request
// S_RESP | ready pulse; access was committed on the edge entering here
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_uns;
  logic [AW+1:0] lat_adr;
  logic [31:0]   lat_wd;

  logic [31:0] mem [DEPTH_WORDS];

  logic accept;
  logic commit;

  // Request fields seen by the access logic: live bus while idle (needed when
  // WAIT_STATES=0 commits on the accepting edge), latched copy otherwise.
  logic          cur_we;
  logic [1:0]    cur_size;
  logic          cur_uns;
  logic [AW+1:0] cur_adr;
  logic [31:0]   cur_wd;

  logic          misaligned;
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [3:0]    be;
  logic [31:0]   wd_lanes;
  logic [31:0]   new_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   load_val;
  logic          mem_we;

  logic unused_adr_bits;
  assign unused_adr_bits = ^dataadr[31:AW+2];

  assign accept = (state == S_IDLE) && req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign commit = (state_nxt == S_RESP) && (state != S_RESP);

  always_comb begin
    if (state == S_IDLE) begin
      cur_we   = memwrite;
      cur_size = size;
      cur_uns  = unsigned_ld;
      cur_adr  = dataadr[AW+1:0];
      cur_wd   = writedata;
    end else begin
      cur_we   = lat_we;
      cur_size = lat_size;
      cur_uns  = lat_uns;
      cur_adr  = lat_adr;
      cur_wd   = lat_wd;
    end
  end

  assign misaligned = ((cur_size == 2'b01) && cur_adr[0]) ||
                      (cur_size[1] && (cur_adr[1:0] != 2'b00));
  assign idx      = cur_adr[AW+1:2];
  assign old_word = mem[idx];

  always_comb begin
    be       = 4'b0000;
    wd_lanes = cur_wd;
    case (cur_size)
      2'b00: begin
        be       = 4'b0001 << cur_adr[1:0];
        wd_lanes = {4{cur_wd[7:0]}};
      end
      2'b01: begin
        be       = cur_adr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{cur_wd[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = cur_wd;
      end
    endcase
  end

  always_comb begin
    new_word = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) new_word[8*k +: 8] = wd_lanes[8*k +: 8];
    end
  end

  always_comb begin
    sel_byte = old_word[7:0];
    case (cur_adr[1:0])
      2'd0:    sel_byte = old_word[7:0];
      2'd1:    sel_byte = old_word[15:8];
      2'd2:    sel_byte = old_word[23:16];
      default: sel_byte = old_word[31:24];
    endcase
    sel_half = cur_adr[1] ? old_word[31:16] : old_word[15:0];
    case (cur_size)
      2'b00:   load_val = {{24{~cur_uns & sel_byte[7]}}, sel_byte};
      2'b01:   load_val = {{16{~cur_uns & sel_half[15]}}, sel_half};
      default: load_val = old_word;
    endcase
  end

  assign mem_we = commit && cur_we && !misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      readdata     <= 32'd0;
      ready        <= 1'b0;
      misalign_err <= 1'b0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_uns      <= 1'b0;
      lat_adr      <= '0;
      lat_wd       <= 32'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ready        <= commit;
      misalign_err <= commit && misaligned;
      if (accept) begin
        lat_we   <= memwrite;
        lat_size <= size;
        lat_uns  <= unsigned_ld;
        lat_adr  <= dataadr[AW+1:0];
        lat_wd   <= writedata;
      end
      if (commit) begin
        if (misaligned) begin
          readdata <= 32'd0;
        end else if (!cur_we) begin
          readdata <= load_val;
        end
      end
    end
  end

  // Reset is in the sensitivity list only so that a reset on the commit edge
  // wins over the write; the array contents themselves are never cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (mem_we) begin
      mem[idx] <= new_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=0
  logic        rst_v [2] = '{1'b1, 1'b1};
  logic        req_v [2];
  logic        we_v  [2];
  logic [1:0]  sz_v  [2];
  logic        uns_v [2];
  logic [31:0] adr_v [2];
  logic [31:0] wd_v  [2];
  logic [31:0] rd_v  [2];
  logic        rdy_v [2];
  logic        mis_v [2];

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .memwrite(we_v[0]), .size(sz_v[0]),
    .unsigned_ld(uns_v[0]), .dataadr(adr_v[0]), .writedata(wd_v[0]),
    .readdata(rd_v[0]), .ready(rdy_v[0]), .misalign_err(mis_v[0]));

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .memwrite(we_v[1]), .size(sz_v[1]),
    .unsigned_ld(uns_v[1]), .dataadr(adr_v[1]), .writedata(wd_v[1]),
    .readdata(rd_v[1]), .ready(rdy_v[1]), .misalign_err(mis_v[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mem_m [2][64];
  int          due      [2] = '{-1, -1};
  logic [31:0] pend_rd  [2];
  logic        pend_mis [2];
  logic        pend_keep[2];
  logic [31:0] exp_rd   [2] = '{32'd0, 32'd0};

  logic [31:0] s_rd;
  logic        s_rdy, s_mis;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Byte-level memory model: applies the access and returns what readdata
  // must become (keep=1 means readdata is left untouched).
  function automatic void model(int i, logic we, logic [1:0] sz, logic uns, logic [31:0] adr,
                                logic [31:0] wd, output logic [31:0] rd, output logic mis,
                                output logic keep);
    int nbytes, off, w;
    longint v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off    = int'(adr % 4);
    w      = int'((adr / 4) % 64);
    mis    = (off % nbytes) != 0;
    keep   = 1'b0;
    rd     = 32'd0;
    if (mis) return;
    if (we) begin
      keep = 1'b1;
      for (int b = 0; b < nbytes; b++) mem_m[i][w][8*(off+b) +: 8] = wd[8*b +: 8];
    end else begin
      v = 0;
      for (int b = 0; b < nbytes; b++) v += longint'(mem_m[i][w][8*(off+b) +: 8]) << (8*b);
      if (!uns && nbytes < 4 && v >= (longint'(1) << (8*nbytes-1))) v -= (longint'(1) << (8*nbytes));
      rd = v[31:0];
    end
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic er, em;
      er = (cyc == due[i]);
      em = 1'b0;
      if (er) begin
        em = pend_mis[i];
        if (pend_mis[i]) exp_rd[i] = 32'd0;
        else if (!pend_keep[i]) exp_rd[i] = pend_rd[i];
      end
      chk($sformatf("ready%0d", i), {31'd0, rdy_v[i]}, {31'd0, er});
      chk($sformatf("misalign%0d", i), {31'd0, mis_v[i]}, {31'd0, em});
      chk($sformatf("readdata%0d", i), rd_v[i], exp_rd[i]);
    end
  end

  task automatic do_req(int i, logic we, logic [1:0] sz, logic uns, logic [31:0] adr,
                        logic [31:0] wd, bit hold);
    logic [31:0] r;
    logic m, k;
    @(negedge clk);
    req_v[i] = 1'b1; we_v[i] = we; sz_v[i] = sz; uns_v[i] = uns; adr_v[i] = adr; wd_v[i] = wd;
    @(posedge clk);
    #1;
    if (!hold) req_v[i] = 1'b0;
    model(i, we, sz, uns, adr, wd, r, m, k);
    pend_rd[i] = r; pend_mis[i] = m; pend_keep[i] = k;
    due[i] = cyc + ws_of(i);
    repeat (ws_of(i)) @(posedge clk);
    @(negedge clk);
    s_rd = rd_v[0 + i]; s_rdy = rdy_v[i]; s_mis = mis_v[i];
    @(posedge clk);
  endtask

  task automatic lit(string nm, logic [31:0] rd, logic mis);
    chk({nm, " rdy"}, {31'd0, s_rdy}, 32'd1);
    chk({nm, " mis"}, {31'd0, s_mis}, {31'd0, mis});
    chk({nm, " rd"}, s_rd, rd);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 0; we_v[i] = 0; sz_v[i] = 0; uns_v[i] = 0; adr_v[i] = 0; wd_v[i] = 0;
    end
    #1;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rd", rd_v[0], 32'd0);
    chk("reset rdy", {31'd0, rdy_v[0]}, 32'd0);
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    @(negedge clk);

    // store then load, byte/half extraction with sign/zero extension
    do_req(0, 1, 2'd2, 0, 32'd84, 32'h80007F02, 0);
    chk("sw84 rdy", {31'd0, s_rdy}, 32'd1);
    do_req(0, 0, 2'd2, 0, 32'd84, 32'd0, 0);       lit("lw84", 32'h80007F02, 0);
    do_req(0, 0, 2'd0, 1, 32'd84, 32'd0, 0);       lit("lbu84", 32'h00000002, 0);
    do_req(0, 0, 2'd0, 0, 32'd85, 32'd0, 0);       lit("lb85", 32'h0000007F, 0);
    do_req(0, 0, 2'd0, 0, 32'd87, 32'd0, 0);       lit("lb87", 32'hFFFFFF80, 0);
    do_req(0, 0, 2'd1, 1, 32'd86, 32'd0, 0);       lit("lhu86", 32'h00008000, 0);
    do_req(0, 0, 2'd1, 0, 32'd86, 32'd0, 0);       lit("lh86", 32'hFFFF8000, 0);

    // partial-lane stores preserve the other lanes
    do_req(0, 1, 2'd2, 0, 32'd80, 32'hFFFFFFFF, 0);
    do_req(0, 1, 2'd0, 0, 32'd81, 32'h00000012, 0);
    do_req(0, 0, 2'd2, 0, 32'd80, 32'd0, 0);       lit("lw80a", 32'hFFFF12FF, 0);
    do_req(0, 1, 2'd1, 0, 32'd82, 32'h0000ABCD, 0);
    do_req(0, 0, 2'd2, 0, 32'd80, 32'd0, 0);       lit("lw80b", 32'hABCD12FF, 0);

    // misaligned accesses
    do_req(0, 1, 2'd2, 0, 32'd82, 32'h01234567, 0); lit("sw82 mis", 32'd0, 1);
    do_req(0, 0, 2'd1, 0, 32'd85, 32'd0, 0);       lit("lh85 mis", 32'd0, 1);
    do_req(0, 0, 2'd2, 0, 32'd80, 32'd0, 0);       lit("lw80c", 32'hABCD12FF, 0);

    // reset while in WAIT aborts the store
    @(negedge clk);
    req_v[0] = 1; we_v[0] = 1; sz_v[0] = 2'd2; uns_v[0] = 0; adr_v[0] = 32'd84; wd_v[0] = 32'h5555AAAA;
    @(posedge clk);
    #1;
    req_v[0] = 0;
    #2;
    rst_v[0] = 1'b0;
    due[0] = -1; exp_rd[0] = 32'd0;
    #1;
    chk("rstwait rd", rd_v[0], 32'd0);
    chk("rstwait rdy", {31'd0, rdy_v[0]}, 32'd0);
    chk("rstwait mis", {31'd0, mis_v[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    do_req(0, 0, 2'd2, 0, 32'd84, 32'd0, 0);       lit("lw84 post-rst", 32'h80007F02, 0);

    // zero-wait instance: req held high, alternating sw/lw, address aliasing
    do_req(1, 1, 2'd2, 0, 32'd0,   32'h11223344, 1); chk("z sw0 rdy", {31'd0, s_rdy}, 32'd1);
    do_req(1, 0, 2'd2, 0, 32'd0,   32'd0, 1);        lit("z lw0", 32'h11223344, 0);
    do_req(1, 1, 2'd2, 0, 32'd256, 32'hCAFEF00D, 1); chk("z sw256 rdy", {31'd0, s_rdy}, 32'd1);
    do_req(1, 0, 2'd2, 0, 32'd0,   32'd0, 0);        lit("z lw0 alias", 32'hCAFEF00D, 0);

    // randomized traffic on the wait-state instance
    for (int w = 0; w < 64; w++)
      do_req(0, 1, 2'd2, 0, (32'($urandom_range(0, 15)) << 8) | 32'(w * 4), $urandom(), 0);
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = $urandom();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom(), 1'($urandom_range(0, 1)));
      #1;
      req_v[0] = 0;
    end
    for (int n = 0; n < 40; n++) begin
      do_req(1, 1'($urandom_range(0, 1)), 2'd2, 0, 32'($urandom_range(0, 1)) << 8, $urandom(), 1);
    end
    #1;
    req_v[1] = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
